sym_err_counter: RTL and testbench

Windowed symbol- and bit-error counter for the 4-ASK receive path. It sits directly downstream of the receive performance modules and compares each sliced receive symbol against the synchronised, delayed transmit reference. Error totals are accumulated over one LFSR period, delimited by `cycle_periodic`. At each window boundary it publishes the totals, a valid pulse and a loss-of-sync flag.

---
 rtl/sym_err_counter_pkg.sv | 19 +
 rtl/sym_err_counter_if.sv | 27 ++
 rtl/sym_err_counter_sat_acc.sv | 35 +++
 rtl/sym_err_counter.sv | 97 +++++++++
 tb/tb_sym_err_counter.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/sym_err_counter_pkg.sv
// Shared types and defaults for the windowed symbol/bit error counter.
// Counter width follows the LFSR length so one period always fits.
package sym_err_counter_pkg;

  localparam int          LFSR_LEN       = 16;
  localparam int          DEF_CNT_W      = LFSR_LEN;
  localparam int unsigned DEF_ERR_THRESH = 32;

  typedef enum logic [1:0] {
    SEC_IDLE    = 2'd0,
    SEC_ARMED   = 2'd1,
    SEC_MEASURE = 2'd2
  } state_t;

  function automatic logic [1:0] popcount2(input logic [1:0] v);
    return {1'b0, v[1]} + {1'b0, v[0]};
  endfunction

endpackage

// File: rtl/sym_err_counter_if.sv
// Symbol stream in, per-window error totals out; no back-pressure, results
// are simply overwritten at the next window boundary.
interface sym_err_counter_if #(
  parameter int CNT_W = 16
);
  logic             sym_clk_en;
  logic             enable;
  logic             cycle_periodic;
  logic [1:0]       rx_data;
  logic [1:0]       ref_data;
  logic [CNT_W-1:0] sym_cnt;
  logic [CNT_W-1:0] sym_err_cnt;
  logic [CNT_W:0]   bit_err_cnt;
  logic             result_valid;
  logic             sync_lost;
  logic [1:0]       state;

  modport master (
    output sym_clk_en, enable, cycle_periodic, rx_data, ref_data,
    input  sym_cnt, sym_err_cnt, bit_err_cnt, result_valid, sync_lost, state
  );

  modport slave (
    input  sym_clk_en, enable, cycle_periodic, rx_data, ref_data,
    output sym_cnt, sym_err_cnt, bit_err_cnt, result_valid, sync_lost, state
  );
endinterface

// File: rtl/sym_err_counter_sat_acc.sv
// Saturating accumulator: sync clear, reload-with-increment, or add; holds at all-ones.
// One-cycle update, no back-pressure.
module sym_err_counter_sat_acc #(
  parameter int W     = 16,
  parameter int INC_W = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             load,
  input  logic             add,
  input  logic [INC_W-1:0] inc,
  output logic [W-1:0]     acc
);

  logic [W-1:0] base;
  logic [W:0]   sum;

  // Load starts a fresh window from the current increment rather than from zero.
  always_comb begin
    base = load ? '0 : acc;
    sum  = {1'b0, base} + (W+1)'(inc);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (load || add) begin
      acc <= sum[W] ? '1 : sum[W-1:0];
    end
  end

endmodule

// File: rtl/sym_err_counter.sv
// Compares sliced rx symbols to the tx reference and publishes error totals per LFSR period.
// Results one cycle after the closing boundary; no back-pressure, outputs overwritten each window.
module sym_err_counter
  import sym_err_counter_pkg::*;
#(
  parameter int          CNT_W      = DEF_CNT_W,
  parameter int unsigned ERR_THRESH = DEF_ERR_THRESH
) (
  input  logic           sys_clk,
  input  logic           reset,
  sym_err_counter_if.slave bus
);

  state_t           st;
  logic [CNT_W-1:0] sym_acc;
  logic [CNT_W-1:0] err_acc;
  logic [CNT_W:0]   bit_acc;
  logic [CNT_W-1:0] sym_q;
  logic [CNT_W-1:0] err_q;
  logic [CNT_W:0]   bit_q;
  logic             valid_q;
  logic             lost_q;

  logic [1:0] diff;
  logic [1:0] sym_inc;
  logic [1:0] err_inc;
  logic [1:0] bit_inc;
  logic       acc_clr;
  logic       acc_load;
  logic       acc_add;

  // A boundary (opening or closing) reloads; a symbol on that same cycle starts the new window.
  always_comb begin
    diff     = bus.rx_data ^ bus.ref_data;
    sym_inc  = bus.sym_clk_en ? 2'd1 : 2'd0;
    err_inc  = (bus.sym_clk_en && diff != 2'b00) ? 2'd1 : 2'd0;
    bit_inc  = bus.sym_clk_en ? popcount2(diff) : 2'd0;
    acc_clr  = !bus.enable;
    acc_load = bus.enable && bus.cycle_periodic &&
               (st == SEC_ARMED || st == SEC_MEASURE);
    acc_add  = bus.enable && bus.sym_clk_en && (st == SEC_MEASURE);
  end

  sym_err_counter_sat_acc #(.W(CNT_W), .INC_W(2)) u_sym_acc (
    .clk(sys_clk), .reset(reset), .clr(acc_clr), .load(acc_load),
    .add(acc_add), .inc(sym_inc), .acc(sym_acc)
  );

  sym_err_counter_sat_acc #(.W(CNT_W), .INC_W(2)) u_err_acc (
    .clk(sys_clk), .reset(reset), .clr(acc_clr), .load(acc_load),
    .add(acc_add), .inc(err_inc), .acc(err_acc)
  );

  sym_err_counter_sat_acc #(.W(CNT_W + 1), .INC_W(2)) u_bit_acc (
    .clk(sys_clk), .reset(reset), .clr(acc_clr), .load(acc_load),
    .add(acc_add), .inc(bit_inc), .acc(bit_acc)
  );

  always_ff @(posedge sys_clk or negedge reset) begin
    if (!reset) begin
      st      <= SEC_IDLE;
      sym_q   <= '0;
      err_q   <= '0;
      bit_q   <= '0;
      valid_q <= 1'b0;
      lost_q  <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (!bus.enable) begin
        st <= SEC_IDLE;
      end else begin
        case (st)
          SEC_IDLE:  st <= SEC_ARMED;
          SEC_ARMED: if (bus.cycle_periodic) st <= SEC_MEASURE;
          SEC_MEASURE: begin
            if (bus.cycle_periodic) begin
              sym_q   <= sym_acc;
              err_q   <= err_acc;
              bit_q   <= bit_acc;
              valid_q <= 1'b1;
              lost_q  <= 32'(err_acc) > ERR_THRESH;
            end
          end
          default:   st <= SEC_IDLE;
        endcase
      end
    end
  end

  assign bus.sym_cnt      = sym_q;
  assign bus.sym_err_cnt  = err_q;
  assign bus.bit_err_cnt  = bit_q;
  assign bus.result_valid = valid_q;
  assign bus.sync_lost    = lost_q;
  assign bus.state        = st;

endmodule

// File: tb/tb_sym_err_counter.sv
// Bench for sym_err_counter: table of windows with hand-derived totals fed through a
// result scoreboard, plus sequences for boundary, enable, reset and saturation cases.
module tb_sym_err_counter;

  typedef struct {
    int sym;
    int err;
    int bits;
    int lost;
  } exp_t;

  typedef struct {
    int         n_sym;
    int         n_a;
    logic [1:0] xa;
    int         n_b;
    logic [1:0] xb;
    exp_t       e;
  } vec_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  exp_t sbq[$];
  exp_t mon_e;
  vec_t vecs[6];

  sym_err_counter_if #(.CNT_W(16)) bus16 ();
  sym_err_counter_if #(.CNT_W(4))  bus4 ();

  sym_err_counter #(.CNT_W(16), .ERR_THRESH(32)) dut (
    .sys_clk(clk), .reset(rst), .bus(bus16)
  );

  sym_err_counter #(.CNT_W(4), .ERR_THRESH(32)) dut4 (
    .sys_clk(clk), .reset(rst), .bus(bus4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic cyc(input logic sce, input logic cp, input logic [1:0] rx, input logic [1:0] rf);
    bus16.sym_clk_en     = sce;
    bus16.cycle_periodic = cp;
    bus16.rx_data        = rx;
    bus16.ref_data       = rf;
    @(posedge clk);
    #1;
  endtask

  task automatic cyc4(input logic sce, input logic cp, input logic [1:0] rx, input logic [1:0] rf);
    bus4.sym_clk_en     = sce;
    bus4.cycle_periodic = cp;
    bus4.rx_data        = rx;
    bus4.ref_data       = rf;
    @(posedge clk);
    #1;
  endtask

  // Each symbol is followed by a strobe-low cycle carrying random data that must not count.
  task automatic run_window(input int n, input int na, input logic [1:0] xa,
                            input int nb, input logic [1:0] xb);
    logic [1:0] rf;
    logic [1:0] x;
    for (int i = 0; i < n; i++) begin
      rf = 2'($urandom_range(0, 3));
      x  = (i < na) ? xa : ((i < na + nb) ? xb : 2'b00);
      cyc(1'b1, 1'b0, rf ^ x, rf);
      cyc(1'b0, 1'b0, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
    end
  endtask

  always @(negedge clk) begin
    if (rst && bus16.result_valid === 1'b1) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result_valid: got 1 expected 0 (sym_cnt %0d)", bus16.sym_cnt);
      end else begin
        mon_e = sbq.pop_front();
        check("sb_sym_cnt",     32'(bus16.sym_cnt),     mon_e.sym);
        check("sb_sym_err_cnt", 32'(bus16.sym_err_cnt), mon_e.err);
        check("sb_bit_err_cnt", 32'(bus16.bit_err_cnt), mon_e.bits);
        check("sb_sync_lost",   32'(bus16.sync_lost),   mon_e.lost);
      end
    end
  end

  initial begin
    checks = 0;
    errors = 0;
    vecs[0] = '{255, 0,  2'b00, 0,  2'b00, '{255, 0,  0,  0}};
    vecs[1] = '{255, 10, 2'b01, 5,  2'b11, '{255, 15, 20, 0}};
    vecs[2] = '{255, 33, 2'b01, 0,  2'b00, '{255, 33, 33, 1}};
    vecs[3] = '{255, 0,  2'b00, 0,  2'b00, '{255, 0,  0,  0}};
    vecs[4] = '{255, 32, 2'b10, 0,  2'b00, '{255, 32, 32, 0}};
    vecs[5] = '{100, 0,  2'b00, 16, 2'b11, '{100, 16, 32, 0}};

    rst = 1'b0;
    bus16.enable = 1'b0;
    bus4.enable  = 1'b0;
    cyc(1'b0, 1'b0, 2'b00, 2'b00);
    cyc4(1'b0, 1'b0, 2'b00, 2'b00);
    check("rst_sym_cnt",      32'(bus16.sym_cnt),      0);
    check("rst_sym_err_cnt",  32'(bus16.sym_err_cnt),  0);
    check("rst_bit_err_cnt",  32'(bus16.bit_err_cnt),  0);
    check("rst_result_valid", 32'(bus16.result_valid), 0);
    check("rst_sync_lost",    32'(bus16.sync_lost),    0);
    check("rst_state",        32'(bus16.state),        0);
    rst = 1'b1;

    bus16.enable = 1'b1;
    cyc(1'b0, 1'b0, 2'b00, 2'b00);
    check("state_armed", 32'(bus16.state), 1);
    cyc(1'b0, 1'b1, 2'b00, 2'b00);
    check("state_measure", 32'(bus16.state), 2);

    foreach (vecs[v]) begin
      run_window(vecs[v].n_sym, vecs[v].n_a, vecs[v].xa, vecs[v].n_b, vecs[v].xb);
      sbq.push_back(vecs[v].e);
      cyc(1'b0, 1'b1, 2'b00, 2'b00);
    end
    check("state_still_measure", 32'(bus16.state), 2);

    // Error symbol coincident with the boundary belongs to the new window.
    run_window(10, 0, 2'b00, 0, 2'b00);
    sbq.push_back('{10, 0, 0, 0});
    cyc(1'b1, 1'b1, 2'b10 ^ 2'b01, 2'b10);
    run_window(9, 0, 2'b00, 0, 2'b00);
    sbq.push_back('{10, 1, 1, 0});
    cyc(1'b0, 1'b1, 2'b00, 2'b00);
    cyc(1'b0, 1'b0, 2'b00, 2'b00);

    // Enable dropped together with a boundary: nothing published, outputs hold.
    run_window(5, 5, 2'b11, 0, 2'b00);
    bus16.enable = 1'b0;
    cyc(1'b1, 1'b1, 2'b11, 2'b00);
    cyc(1'b0, 1'b0, 2'b00, 2'b00);
    check("en_drop_state",   32'(bus16.state),        0);
    check("en_drop_valid",   32'(bus16.result_valid), 0);
    check("en_hold_sym_cnt", 32'(bus16.sym_cnt),      10);
    check("en_hold_err_cnt", 32'(bus16.sym_err_cnt),  1);
    check("en_hold_bit_cnt", 32'(bus16.bit_err_cnt),  1);

    // Reset mid-window clears immediately; leftover errors must not leak into the next window.
    bus16.enable = 1'b1;
    cyc(1'b0, 1'b0, 2'b00, 2'b00);
    cyc(1'b0, 1'b1, 2'b00, 2'b00);
    run_window(4, 4, 2'b01, 0, 2'b00);
    rst = 1'b0;
    #1;
    check("arst_sym_cnt",   32'(bus16.sym_cnt),     0);
    check("arst_err_cnt",   32'(bus16.sym_err_cnt), 0);
    check("arst_bit_cnt",   32'(bus16.bit_err_cnt), 0);
    check("arst_state",     32'(bus16.state),       0);
    #2;
    rst = 1'b1;
    cyc(1'b0, 1'b0, 2'b00, 2'b00);
    check("post_rst_armed", 32'(bus16.state), 1);
    cyc(1'b0, 1'b1, 2'b00, 2'b00);
    run_window(3, 0, 2'b00, 0, 2'b00);
    sbq.push_back('{3, 0, 0, 0});
    cyc(1'b0, 1'b1, 2'b00, 2'b00);
    cyc(1'b0, 1'b0, 2'b00, 2'b00);
    cyc(1'b0, 1'b0, 2'b00, 2'b00);
    check("sb_drained", 32'(sbq.size()), 0);

    // Narrow instance: 20 double-bit errors saturate every accumulator.
    bus4.enable = 1'b1;
    cyc4(1'b0, 1'b0, 2'b00, 2'b00);
    cyc4(1'b0, 1'b1, 2'b00, 2'b00);
    for (int i = 0; i < 20; i++) begin
      cyc4(1'b1, 1'b0, 2'b11, 2'b00);
      cyc4(1'b0, 1'b0, 2'b00, 2'b00);
    end
    cyc4(1'b0, 1'b1, 2'b00, 2'b00);
    check("sat_valid",   32'(bus4.result_valid), 1);
    check("sat_sym_cnt", 32'(bus4.sym_cnt),      15);
    check("sat_err_cnt", 32'(bus4.sym_err_cnt),  15);
    check("sat_bit_cnt", 32'(bus4.bit_err_cnt),  31);
    check("sat_lost",    32'(bus4.sync_lost),    0);
    cyc4(1'b0, 1'b0, 2'b00, 2'b00);
    check("sat_valid_one_cycle", 32'(bus4.result_valid), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
